// File: rtl/ctrl_fsm_if.sv
// Control bundle between the sequencer and the datapath: opcode/flags/ready in, strobes out.
interface ctrl_fsm_if;
  logic [3:0] opcode;
  logic [1:0] flag_fl;
  logic       mem_ready;
  logic       Pc_Rst;
  logic       Pc_Inc;
  logic       Pc_Ld;
  logic       pc_src;
  logic       Lir;
  logic       rd;
  logic       wr;
  logic       Spc;
  logic       Ssp;
  logic       Sp_Rst;
  logic       Sp_inc;
  logic       Sp_dec;
  logic [2:0] alu_op;
  logic       Efl;
  logic       reg_we;
  logic       reg_src;
  logic       halted;
  logic       bus_err;

  modport master (
    input  opcode, flag_fl, mem_ready,
    output Pc_Rst, Pc_Inc, Pc_Ld, pc_src, Lir, rd, wr, Spc, Ssp,
           Sp_Rst, Sp_inc, Sp_dec, alu_op, Efl, reg_we, reg_src, halted, bus_err
  );

  modport slave (
    output opcode, flag_fl, mem_ready,
    input  Pc_Rst, Pc_Inc, Pc_Ld, pc_src, Lir, rd, wr, Spc, Ssp,
           Sp_Rst, Sp_inc, Sp_dec, alu_op, Efl, reg_we, reg_src, halted, bus_err
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Hardwired fetch/decode/execute/memory sequencer: 3 cycles per instruction, 4 with a memory stage.
// Stalls in FETCH/MEM until mem_ready; after TIMEOUT wait cycles it flags bus_err and halts.
module ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clkin,
  input logic        Rst,
  ctrl_fsm_if.master bus
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Timeout fires on the TIMEOUT-th consecutive wait cycle unless ready arrives in it.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [3:0] r_op;
  logic [7:0] r_cnt;
  logic       r_bus_err;
  logic       w_wait;
  logic       w_timeout;

  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_timeout = w_wait && (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RST:    w_state_nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) w_state_nxt = S_DECODE;
                else if (w_timeout) w_state_nxt = S_HALT;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_LD, OP_ST, OP_CALL, OP_RET: w_state_nxt = S_MEM;
          OP_HLT:                        w_state_nxt = S_HALT;
          default:                       w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    if (bus.mem_ready) w_state_nxt = S_FETCH;
                else if (w_timeout) w_state_nxt = S_HALT;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clkin or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_RST;
      r_op      <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) r_op <= bus.opcode;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_wait)            r_cnt <= r_cnt + 8'd1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign bus.halted  = (r_state == S_HALT);
  assign bus.bus_err = r_bus_err;

  always_comb begin
    bus.Pc_Rst  = 1'b0;
    bus.Pc_Inc  = 1'b0;
    bus.Pc_Ld   = 1'b0;
    bus.pc_src  = 1'b0;
    bus.Lir     = 1'b0;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.Spc     = 1'b0;
    bus.Ssp     = 1'b0;
    bus.Sp_Rst  = 1'b0;
    bus.Sp_inc  = 1'b0;
    bus.Sp_dec  = 1'b0;
    bus.alu_op  = 3'd0;
    bus.Efl     = 1'b0;
    bus.reg_we  = 1'b0;
    bus.reg_src = 1'b0;
    case (r_state)
      S_RST: begin
        bus.Pc_Rst = 1'b1;
        bus.Sp_Rst = 1'b1;
      end
      S_FETCH: begin
        bus.rd     = 1'b1;
        bus.Spc    = 1'b1;
        bus.Lir    = bus.mem_ready;
        bus.Pc_Inc = bus.mem_ready;
      end
      S_EXEC: begin
        case (r_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            bus.alu_op = r_op[2:0];
            bus.Efl    = 1'b1;
            bus.reg_we = 1'b1;
          end
          OP_CMP: begin
            bus.alu_op = 3'd2;
            bus.Efl    = 1'b1;
          end
          OP_JMP:  bus.Pc_Ld  = 1'b1;
          OP_JZ:   bus.Pc_Ld  = bus.flag_fl[0];
          OP_JC:   bus.Pc_Ld  = bus.flag_fl[1];
          OP_RET:  bus.Sp_inc = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        // Data address is selected when both Spc and Ssp are low.
        case (r_op)
          OP_LD: begin
            bus.rd      = 1'b1;
            bus.reg_we  = bus.mem_ready;
            bus.reg_src = bus.mem_ready;
          end
          OP_ST:   bus.wr = 1'b1;
          OP_CALL: begin
            bus.wr     = 1'b1;
            bus.Ssp    = 1'b1;
            bus.Sp_dec = bus.mem_ready;
            bus.Pc_Ld  = bus.mem_ready;
          end
          OP_RET: begin
            bus.rd     = 1'b1;
            bus.Ssp    = 1'b1;
            bus.Pc_Ld  = bus.mem_ready;
            bus.pc_src = bus.mem_ready;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: per-cycle expected strobes come from an instruction-phase model
// (fetch waits, decode, execute, memory waits, completion) built into queues.
module tb_ctrl_fsm;

  typedef struct packed {
    logic       Pc_Rst, Pc_Inc, Pc_Ld, pc_src, Lir, rd, wr, Spc, Ssp, Sp_Rst, Sp_inc, Sp_dec;
    logic [2:0] alu_op;
    logic       Efl, reg_we, reg_src, halted, bus_err;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_checks = 0;
  outs_t got;

  outs_t      exp_q[$];
  bit         rdy_q[$];
  logic [3:0] opc_q[$];
  logic [1:0] fl_q[$];

  ctrl_fsm_if bus ();

  ctrl_fsm #(.TIMEOUT(4)) dut (
    .clkin (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    o.Pc_Rst = bus.Pc_Rst;  o.Pc_Inc = bus.Pc_Inc;  o.Pc_Ld = bus.Pc_Ld;  o.pc_src = bus.pc_src;
    o.Lir = bus.Lir;        o.rd = bus.rd;          o.wr = bus.wr;        o.Spc = bus.Spc;
    o.Ssp = bus.Ssp;        o.Sp_Rst = bus.Sp_Rst;  o.Sp_inc = bus.Sp_inc; o.Sp_dec = bus.Sp_dec;
    o.alu_op = bus.alu_op;  o.Efl = bus.Efl;        o.reg_we = bus.reg_we; o.reg_src = bus.reg_src;
    o.halted = bus.halted;  o.bus_err = bus.bus_err;
    return o;
  endfunction

  function automatic outs_t v_rst();
    outs_t e = '0;
    e.Pc_Rst = 1'b1;
    e.Sp_Rst = 1'b1;
    return e;
  endfunction

  function automatic outs_t v_fetch();
    outs_t e = '0;
    e.rd  = 1'b1;
    e.Spc = 1'b1;
    return e;
  endfunction

  function automatic outs_t v_halt(input logic be);
    outs_t e = '0;
    e.halted  = 1'b1;
    e.bus_err = be;
    return e;
  endfunction

  function automatic void clr();
    exp_q.delete(); rdy_q.delete(); opc_q.delete(); fl_q.delete();
  endfunction

  function automatic void drop_last();
    exp_q.delete(exp_q.size() - 1); rdy_q.delete(rdy_q.size() - 1);
    opc_q.delete(opc_q.size() - 1); fl_q.delete(fl_q.size() - 1);
  endfunction

  function automatic void push(input outs_t e, input bit r, input logic [3:0] o, input logic [1:0] f);
    exp_q.push_back(e); rdy_q.push_back(r); opc_q.push_back(o); fl_q.push_back(f);
  endfunction

  // One instruction: fw fetch waits, fetch completion, decode, execute, then an optional
  // memory phase with mw waits. Opcode is garbage once decoded; flags matter only in execute.
  function automatic void model_instr(input logic [3:0] op, input logic [1:0] fl,
                                      input int fw, input int mw);
    outs_t e, req;
    bit    is_mem;
    for (int i = 0; i < fw; i++) push(v_fetch(), 1'b0, op, 2'($urandom));
    e = v_fetch(); e.Lir = 1'b1; e.Pc_Inc = 1'b1;
    push(e, 1'b1, op, 2'($urandom));
    push('0, 1'($urandom), op, 2'($urandom));
    e = '0;
    if (op >= 4'h1 && op <= 4'h6) begin
      e.alu_op = op[2:0]; e.Efl = 1'b1; e.reg_we = 1'b1;
    end else if (op == 4'hE) begin
      e.alu_op = 3'd2; e.Efl = 1'b1;
    end else if (op == 4'h9) e.Pc_Ld = 1'b1;
    else if (op == 4'hA)     e.Pc_Ld = fl[0];
    else if (op == 4'hB)     e.Pc_Ld = fl[1];
    else if (op == 4'hD)     e.Sp_inc = 1'b1;
    push(e, 1'($urandom), 4'($urandom), fl);
    is_mem = (op == 4'h7) || (op == 4'h8) || (op == 4'hC) || (op == 4'hD);
    if (is_mem) begin
      req = '0;
      req.rd  = (op == 4'h7) || (op == 4'hD);
      req.wr  = (op == 4'h8) || (op == 4'hC);
      req.Ssp = (op == 4'hC) || (op == 4'hD);
      for (int i = 0; i < mw; i++) push(req, 1'b0, 4'($urandom), 2'($urandom));
      e = req;
      if (op == 4'h7) begin e.reg_we = 1'b1; e.reg_src = 1'b1; end
      if (op == 4'hC) begin e.Sp_dec = 1'b1; e.Pc_Ld = 1'b1; end
      if (op == 4'hD) begin e.Pc_Ld = 1'b1; e.pc_src = 1'b1; end
      push(e, 1'b1, 4'($urandom), 2'($urandom));
    end
  endfunction

  task automatic cyc(input bit r, input logic [3:0] o, input logic [1:0] f, output outs_t s);
    bus.mem_ready = r;
    bus.opcode    = o;
    bus.flag_fl   = f;
    @(negedge clk);
    s = sample();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle, one time unit after the clock edge.
  task automatic do_reset();
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1; bus.opcode = 4'hF; bus.flag_fl = 2'b11;
    #2 rst = 1'b1;
    #1 got = sample();
    n_checks++;
    if (got !== v_rst()) begin n_err++; $display("FAIL reset_async got=%h exp=%h", got, v_rst()); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== v_rst()) begin n_err++; $display("FAIL reset_rst_state got=%h exp=%h", got, v_rst()); end
    @(posedge clk);
    #1;
    clr();
    model_instr(4'h7, 2'b00, 0, 1);
    drop_last();
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL reset_pre[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    #1 rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1 got = sample();
    n_checks++;
    if (got !== v_rst()) begin n_err++; $display("FAIL reset_mid_mem got=%h exp=%h", got, v_rst()); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample();
      n_checks++;
      if (got !== v_rst()) begin n_err++; $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, v_rst()); end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== v_rst()) begin n_err++; $display("FAIL reset_release got=%h exp=%h", got, v_rst()); end
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== v_fetch()) begin n_err++; $display("FAIL reset_first_fetch got=%h exp=%h", got, v_fetch()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_ld();
    do_reset();
    clr();
    model_instr(4'h1, 2'($urandom), 0, 0);
    model_instr(4'h7, 2'($urandom), 0, 2);
    model_instr(4'hE, 2'($urandom), 0, 0);
    model_instr(4'h6, 2'($urandom), 1, 0);
    model_instr(4'h8, 2'($urandom), 0, 1);
    model_instr(4'h0, 2'($urandom), 0, 0);
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL alu_ld[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_jumps();
    do_reset();
    clr();
    model_instr(4'hA, 2'b01, 0, 0);
    model_instr(4'hA, 2'b00, 0, 0);
    model_instr(4'hA, 2'b10, 0, 0);
    model_instr(4'hB, 2'b10, 0, 0);
    model_instr(4'hB, 2'b01, 0, 0);
    model_instr(4'h9, 2'($urandom), 0, 0);
    model_instr(4'h1, 2'($urandom), 0, 0);
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL jumps[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    clr();
    model_instr(4'hC, 2'($urandom), 0, 0);
    model_instr(4'hD, 2'($urandom), 0, 1);
    model_instr(4'hC, 2'($urandom), 2, 2);
    model_instr(4'hD, 2'($urandom), 0, 0);
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL call_ret[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    clr();
    for (int i = 0; i < 4; i++) push(v_fetch(), 1'b0, 4'($urandom), 2'($urandom));
    for (int i = 0; i < 6; i++) push(v_halt(1'b1), 1'($urandom), 4'($urandom), 2'($urandom));
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL timeout_fetch[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    do_reset();
    clr();
    model_instr(4'h8, 2'($urandom), 0, 4);
    drop_last();
    for (int i = 0; i < 4; i++) push(v_halt(1'b1), 1'($urandom), 4'($urandom), 2'($urandom));
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL timeout_mem[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_ready_last_wait();
    do_reset();
    clr();
    model_instr(4'h1, 2'($urandom), 3, 0);
    model_instr(4'h7, 2'($urandom), 0, 3);
    model_instr(4'hC, 2'($urandom), 3, 3);
    model_instr(4'h0, 2'($urandom), 3, 0);
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL ready_last[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_hlt();
    do_reset();
    clr();
    model_instr(4'h2, 2'($urandom), 0, 0);
    model_instr(4'hF, 2'($urandom), 1, 0);
    for (int i = 0; i < 5; i++) push(v_halt(1'b0), 1'($urandom), 4'($urandom), 2'($urandom));
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL hlt[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clr();
    for (int k = 0; k < 60; k++)
      model_instr(4'($urandom_range(0, 14)), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    foreach (exp_q[i]) begin
      cyc(rdy_q[i], opc_q[i], fl_q[i], got);
      n_checks++;
      if (got !== exp_q[i]) begin n_err++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode    = 4'h0;
    bus.flag_fl   = 2'b00;
    test_reset();
    test_alu_ld();
    test_jumps();
    test_call_ret();
    test_timeout();
    test_ready_last_wait();
    test_hlt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Hardwired control sequencer for the processor datapath. It drives fetch, decode, execute and memory cycles by issuing load, select and enable strobes to the program counter, instruction register, register file, ALU flag register, stack pointer, address selector and memory. It replaces free-running microsequencing with an explicit state machine. It adds a memory-ready handshake with timeout and a halt state.

## Interface

Parameters:

- TIMEOUT, 15, max cycles to wait for mem_ready before bus error (1..255)

Ports:

- clkin  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- opcode  in  4  opcode field from instruction register
- flag_fl  in  2  latched flags: [0]=Z, [1]=C
- mem_ready  in  1  memory completes current access this cycle
- Pc_Rst  out  1  clear PC
- Pc_Inc  out  1  PC <= PC+1
- Pc_Ld  out  1  PC <= load value
- pc_src  out  1  PC load source: 0 = IR operand, 1 = memory data
- Lir  out  1  load instruction register
- rd  out  1  memory read request
- wr  out  1  memory write request
- Spc  out  1  address select: PC
- Ssp  out  1  address select: stack pointer (data address when both 0)
- Sp_Rst, Sp_inc, Sp_dec  out  1 each  stack pointer controls
- alu_op  out  3  ALU function
- Efl  out  1  load flag register
- reg_we  out  1  register file write
- reg_src  out  1  write source: 0 = ALU, 1 = memory
- halted  out  1  core stopped
- bus_err  out  1  sticky memory timeout indicator

## Operation

- States: RST, FETCH, DECODE, EXEC, MEM, HALT.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 LD, 8 ST, 9 JMP, A JZ, B JC, C CALL, D RET, E CMP, F HLT.
- RST:
  - Assert Pc_Rst and Sp_Rst.
  - Go to FETCH next cycle.
- FETCH:
  - Assert rd and Spc.
  - When mem_ready=1, assert Lir and Pc_Inc in the same cycle, then go to DECODE.
- DECODE:
  - Latch opcode into internal op_q.
  - Go to EXEC.
- EXEC, by op_q:
  - NOP: go to FETCH.
  - 1–6: alu_op=op_q[2:0], Efl=1, reg_we=1, reg_src=0, then FETCH.
  - CMP: alu_op=3'd2, Efl=1, reg_we=0, then FETCH.
  - JMP: Pc_Ld=1, pc_src=0, then FETCH.
  - JZ: Pc_Ld=flag_fl[0], then FETCH.
  - JC: Pc_Ld=flag_fl[1], then FETCH.
  - LD, ST, CALL: go to MEM.
  - RET: Sp_inc=1, then MEM.
  - HLT: go to HALT.
- MEM, holding requests until mem_ready:
  - LD: rd=1, Spc=Ssp=0. On ready: reg_we=1, reg_src=1.
  - ST: wr=1, Spc=Ssp=0.
  - CALL: wr=1, Ssp=1. On ready: Sp_dec=1, Pc_Ld=1, pc_src=0.
  - RET: rd=1, Ssp=1. On ready: Pc_Ld=1, pc_src=1.
  - Every case goes to FETCH after ready.
- Wait counter:
  - Cleared on entering FETCH or MEM.
  - Increments each cycle the state holds without mem_ready.
  - When the count reaches TIMEOUT, set bus_err and go to HALT. mem_ready arriving in that same cycle wins (normal completion).
- HALT:
  - All strobes 0, halted=1.
  - Left only by Rst.
- Outputs are combinational from state, op_q, flag_fl and mem_ready. Only state, op_q, the wait counter and bus_err are registered.

## Timing

- Rst high: state=RST immediately (async), counter=0, bus_err=0, op_q=0.
  - Outputs during reset: Pc_Rst=1, Sp_Rst=1, all other outputs 0.
- First FETCH is one clkin edge after Rst deasserts.
- Instruction latency with zero-wait memory (mem_ready tied high):
  - ALU, CMP, NOP, jumps: 3 cycles.
  - LD, ST, CALL, RET: 4 cycles.
  - Each wait cycle adds 1.
- Strobes qualified by mem_ready (Lir, Pc_Inc, Sp_dec, memory-stage Pc_Ld and reg_we) are single-cycle pulses.
- Requests (rd, wr) stay stable from state entry until the ready cycle inclusive.
- Flags are sampled in the EXEC cycle. A CMP immediately followed by JZ sees the updated flag, because Efl commits at the edge that ends CMP's EXEC.
- Rst mid-access aborts the access. No completion strobe is issued.

## Test plan

- Reset: hold Rst 3 cycles mid-MEM -> Pc_Rst=Sp_Rst=1, rd=wr=0, bus_err=0. Release -> RST for 1 cycle, then FETCH with rd=Spc=1.
- ADD with mem_ready=1 -> Lir/Pc_Inc pulse in cycle 1, alu_op=3'd1 with Efl=reg_we=1 in cycle 3, FETCH again in cycle 4.
- LD with 2 wait cycles in MEM -> rd held 3 cycles, reg_we=reg_src=1 only in the ready cycle, 6 cycles total.
- JZ with flag_fl=2'b01 -> Pc_Ld=1. With flag_fl=2'b00 -> Pc_Ld=0. Both return to FETCH after EXEC.
- CALL then RET: CALL gives wr=Ssp=1, then Sp_dec=Pc_Ld=1, pc_src=0. RET gives Sp_inc in EXEC, then rd=Ssp=1, then Pc_Ld=1, pc_src=1.
- Timeout with TIMEOUT=4 and mem_ready stuck 0 in FETCH -> bus_err=1, halted=1 after 4 waits, state stays HALT until Rst. Separately, mem_ready arriving on the 4th wait -> normal completion, bus_err=0.
